imem_boot_loader: RTL

Byte-stream boot loader that sits directly upstream of the `riscv32` core. It receives a framed program image over a valid/ready byte interface, writes it byte-by-byte into instruction memory starting at address 0, and verifies an XOR checksum. On success it raises the core's `start` input and holds it high until reset. It replaces hand-poking `Inst_Mem` from a bench with a synthesizable load path.

---
 rtl/imem_boot_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed program image on a valid/ready byte
// stream, writes the payload into instruction memory from address 0 upward,
// checks an XOR checksum and raises the core's start level on success.
//
// Stream handshake: a byte moves on a rising edge exactly when
// in_valid && in_ready. in_ready depends only on the current state and is low
// only in the terminal DONE/ERR states. The source may drop in_valid at any
// time, and everything holds while it does.
module imem_boot_loader #(
    parameter int          ADDR_W = 14,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              start,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [7:0]          xor_q, xor_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    logic                accept;
    logic [15:0]         full_len;
    logic                len_too_big;
    logic                last_byte;

    assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept    = in_valid && in_ready;

    // Length as it stands once the low byte is on the bus (LEN_LO only).
    assign full_len    = {len_q[15:8], in_data};
    // The counter is one bit wider than the address, so exactly 2^ADDR_W is legal.
    assign len_too_big = 32'(full_len) > (32'd1 << ADDR_W);
    assign last_byte   = 32'(cnt_q) == (32'(len_q) - 32'd1);

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign error     = error_q;

    // Next-state, datapath and registered-output decode for the frame parser.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept && (in_data == SYNC)) begin
                    xor_d   = 8'h00;
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    xor_d       = xor_q ^ in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = full_len;
                    xor_d = xor_q ^ in_data;
                    if (len_too_big) begin
                        state_d = S_ERR;
                    end else if (full_len == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    xor_d       = xor_q ^ in_data;
                    cnt_d       = cnt_q + (ADDR_W+1)'(1);
                    if (last_byte) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                // DONE and ERR are terminal until reset.
            end
        endcase

        start_d = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
        busy_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                  (state_d == S_DATA)   || (state_d == S_CSUM);
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            xor_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

endmodule
